// File: rtl/pmod_keypad_scanner_if.sv
// Key event handshake between the keypad scanner (master) and its consumer (slave).
interface pmod_keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/pmod_keypad_scanner.sv
// 4x4 PMOD keypad scanner: column drive, row sampling, scan-level debounce, event handshake.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module pmod_keypad_scanner #(
    parameter int SCAN_DIV            = 10_000,
    parameter int DEBOUNCE_SCANS      = 50,
    parameter int REPEAT_DELAY_SCANS  = 1250,
    parameter int REPEAT_PERIOD_SCANS = 250
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   row,
    output logic [3:0]                   col,
    pmod_keypad_scanner_if.master        kp
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
    typedef enum logic {IDLE, PRESSED} state_t;
    typedef struct packed {
        cls_t       cls;
        logic [3:0] code;
    } scan_t;

    // Vector bit index is col*4 + row.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'h1;
            4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;
            4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;
            4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;
            4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;
            4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;
            4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;
            4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;
            default: key_map = 4'hD;
        endcase
    endfunction

    function automatic scan_t classify(input logic [15:0] v);
        scan_t s;
        int    n;
        s.cls  = CLS_NONE;
        s.code = 4'h0;
        n      = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                s.code = key_map(4'(i));
            end
        end
        if (n == 1) begin
            s.cls = CLS_SINGLE;
        end else if (n > 1) begin
            s.cls  = CLS_MULTI;
            s.code = 4'h0;
        end
        return s;
    endfunction

    logic [3:0]        row_s1_q, row_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [15:0]       scan_vec_q, scan_vec_d;
    scan_t             prev_q, prev_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    scan_t             cur_scan;
    logic              col_last, scan_done, stable;
    logic              press_evt, release_evt, evt;
    logic [3:0]        evt_code;

    state_t            state_q;
    logic [3:0]        key_code_q;
    logic              key_valid_q, key_held_q, overrun_q;

    assign col_last  = (div_q == DIV_LAST);
    assign scan_done = col_last && (col_idx_q == 2'd3);
    assign col       = ~(4'b0001 << col_idx_q);

    // The final column's sample is folded in combinationally so the scan is judged on its last clock.
    always_comb begin
        div_d      = col_last ? '0 : div_q + 1'b1;
        col_idx_d  = col_last ? col_idx_q + 2'd1 : col_idx_q;
        scan_vec_d = scan_vec_q;
        if (col_last) begin
            scan_vec_d[{col_idx_q, 2'b00} +: 4] = ~row_s2_q;
        end
        cur_scan = classify(scan_vec_d);
        prev_d   = prev_q;
        stab_d   = stab_q;
        if (scan_done) begin
            prev_d = cur_scan;
            if (cur_scan == prev_q) begin
                stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
            end else begin
                stab_d = STAB_W'(1);
            end
        end
    end

    assign stable      = scan_done && (stab_d == STAB_MAX);
    assign press_evt   = stable && (state_q == IDLE)    && (cur_scan.cls == CLS_SINGLE);
    assign release_evt = stable && (state_q == PRESSED) && (cur_scan.cls == CLS_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            scan_vec_q <= 16'h0000;
            prev_q     <= scan_t'{CLS_NONE, 4'h0};
            stab_q     <= '0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            scan_vec_q <= scan_vec_d;
            prev_q     <= prev_d;
            stab_q     <= stab_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_PERIOD_SCANS) ?
                             REPEAT_DELAY_SCANS : REPEAT_PERIOD_SCANS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d, rep_nxt;
    logic             rep_first_q, rep_first_d;
    logic [3:0]       held_code_q, held_code_d;
    logic             rep_evt;

    // Repeat timing only advances on scans that still show the held key alone.
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        held_code_d = held_code_q;
        rep_evt     = 1'b0;
        rep_nxt     = rep_q + 1'b1;
        if (press_evt) begin
            rep_d       = '0;
            rep_first_d = 1'b1;
            held_code_d = cur_scan.code;
        end else if (scan_done && (state_q == PRESSED) && !release_evt &&
                     (cur_scan.cls == CLS_SINGLE) && (cur_scan.code == held_code_q)) begin
            if (rep_nxt == (rep_first_q ? REP_W'(REPEAT_DELAY_SCANS) : REP_W'(REPEAT_PERIOD_SCANS))) begin
                rep_evt     = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_d = rep_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
            held_code_q <= 4'h0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
            held_code_q <= held_code_d;
        end
    end

    assign evt      = press_evt | rep_evt;
    assign evt_code = press_evt ? cur_scan.code : held_code_q;
`else
    assign evt      = press_evt;
    assign evt_code = cur_scan.code;
`endif

    // A coincident ack frees the slot, so the new event loads without flagging overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (press_evt) begin
                state_q    <= PRESSED;
                key_held_q <= 1'b1;
            end else if (release_evt) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
            end
            if (evt) begin
                if (!key_valid_q || kp.key_ack) begin
                    key_code_q  <= evt_code;
                    key_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (key_valid_q && kp.key_ack) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.overrun   = overrun_q;

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Directed bench for pmod_keypad_scanner: a keypad model drives rows from the active column.
module tb_pmod_keypad_scanner;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;   // pressed keys, bit index col*4 + row
    int          checks   = 0;
    int          failures = 0;

`ifdef KEYPAD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    pmod_keypad_scanner_if kp ();

    pmod_keypad_scanner #(
        .SCAN_DIV            (4),
        .DEBOUNCE_SCANS      (3),
        .REPEAT_DELAY_SCANS  (4),
        .REPEAT_PERIOD_SCANS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row   (row),
        .col   (col),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4 + r]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col !== target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (col !== target) begin
            checks++;
            failures++;
            $error("FAIL timeout_col observed=%0h expected=%0h", col, target);
        end
    endtask

    // Returns #1 after the edge that closes a full scan.
    task automatic scan();
        wait_col(4'b0111);
        wait_col(4'b1110);
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) scan();
    endtask

    task automatic ack();
        kp.key_ack = 1'b1;
        @(posedge clk);
        #1;
        kp.key_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},     8'(col),          8'hE);
        check({tag, "_code"},    8'(kp.key_code),  8'h0);
        check({tag, "_valid"},   8'(kp.key_valid), 8'h0);
        check({tag, "_held"},    8'(kp.key_held),  8'h0);
        check({tag, "_overrun"}, 8'(kp.overrun),   8'h0);
    endtask

    initial begin
        kp.key_ack = 1'b0;
        keys       = 16'h0000;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Key 6 (r1,c2) held for five scans, one event, then ack and release
        keys = 16'h0200;
        scans(2);
        check("k6_valid_scan2", 8'(kp.key_valid), 8'h0);
        scan();
        check("k6_valid_scan3", 8'(kp.key_valid), 8'h1);
        check("k6_code",        8'(kp.key_code),  8'h6);
        check("k6_held",        8'(kp.key_held),  8'h1);
        scans(2);
        check("k6_valid_scan5",   8'(kp.key_valid), 8'h1);
        check("k6_overrun_scan5", 8'(kp.overrun),   8'h0);
        ack();
        check("k6_valid_acked", 8'(kp.key_valid), 8'h0);
        keys = 16'h0000;
        scans(2);
        check("k6_held_rel2", 8'(kp.key_held), 8'h1);
        scan();
        check("k6_held_rel3",  8'(kp.key_held),  8'h0);
        check("k6_valid_rel3", 8'(kp.key_valid), 8'h0);

        // Stray ack with nothing pending
        ack();
        check("stray_ack_valid", 8'(kp.key_valid), 8'h0);

        // Key A (r0,c3) bouncing, then stable
        for (int i = 0; i < 3; i++) begin
            keys = 16'h1000;
            scan();
            keys = 16'h0000;
            scan();
        end
        check("kA_bounce_valid", 8'(kp.key_valid), 8'h0);
        keys = 16'h1000;
        scans(2);
        check("kA_valid_scan2", 8'(kp.key_valid), 8'h0);
        scan();
        check("kA_valid_scan3", 8'(kp.key_valid), 8'h1);
        check("kA_code",        8'(kp.key_code),  8'hA);
        ack();
        keys = 16'h0000;
        scans(3);
        check("kA_held_rel", 8'(kp.key_held), 8'h0);

        // Keys 1 and 2 together, then 5 held and 8 added
        keys = 16'h0011;
        scans(6);
        check("multi_valid", 8'(kp.key_valid), 8'h0);
        check("multi_held",  8'(kp.key_held),  8'h0);
        keys = 16'h0000;
        scan();
        keys = 16'h0020;
        scans(3);
        check("k5_valid", 8'(kp.key_valid), 8'h1);
        check("k5_code",  8'(kp.key_code),  8'h5);
        ack();
        keys = 16'h0060;
        scans(5);
        check("k5k8_valid",   8'(kp.key_valid), 8'h0);
        check("k5k8_held",    8'(kp.key_held),  8'h1);
        check("k5k8_overrun", 8'(kp.overrun),   8'h0);
        keys = 16'h0000;
        scans(3);
        check("k5k8_held_rel", 8'(kp.key_held), 8'h0);

        // Key 5 not acked, released, then key 9 (r2,c2): overrun
        keys = 16'h0020;
        scans(3);
        check("ovr_first_code",  8'(kp.key_code),  8'h5);
        check("ovr_first_valid", 8'(kp.key_valid), 8'h1);
        keys = 16'h0000;
        scans(3);
        keys = 16'h0400;
        scans(3);
        check("ovr_code",    8'(kp.key_code),  8'h5);
        check("ovr_valid",   8'(kp.key_valid), 8'h1);
        check("ovr_overrun", 8'(kp.overrun),   8'h1);
        check("ovr_held",    8'(kp.key_held),  8'h1);

        // Reset while key 9 is held and column 2 is being driven
        wait_col(4'b1011);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_col_rel", 8'(col), 8'hE);
        @(posedge clk);
        #1;
        check("midrst_col_rel1", 8'(col), 8'hE);
        scans(2);
        check("redeb_valid_scan2", 8'(kp.key_valid), 8'h0);
        check("redeb_held_scan2",  8'(kp.key_held),  8'h0);
        scan();
        check("redeb_valid", 8'(kp.key_valid), 8'h1);
        check("redeb_code",  8'(kp.key_code),  8'h9);
        check("redeb_held",  8'(kp.key_held),  8'h1);

        // Event arriving on the same clock as the ack of a pending one
        keys = 16'h0000;
        scans(3);
        check("coin_pending_valid", 8'(kp.key_valid), 8'h1);
        keys = 16'h0020;
        scans(2);
        wait_col(4'b0111);
        repeat (3) @(posedge clk);
        #1;
        kp.key_ack = 1'b1;
        @(posedge clk);
        #1;
        kp.key_ack = 1'b0;
        check("coin_valid",   8'(kp.key_valid), 8'h1);
        check("coin_code",    8'(kp.key_code),  8'h5);
        check("coin_overrun", 8'(kp.overrun),   8'h0);
        ack();
        check("coin_acked", 8'(kp.key_valid), 8'h0);
        keys = 16'h0000;
        scans(3);

        // Key D (r3,c3) held for ten scans with immediate acks
        keys = 16'h8000;
        for (int s = 1; s <= 10; s++) begin
            logic exp_evt;
            exp_evt = (s == 3) || (REP && (s == 7 || s == 9));
            scan();
            check($sformatf("kD_valid_scan%0d", s), 8'(kp.key_valid), 8'(exp_evt));
            if (exp_evt) check($sformatf("kD_code_scan%0d", s), 8'(kp.key_code), 8'hD);
            if (kp.key_valid) ack();
        end
        keys = 16'h0000;
        scans(3);
        check("kD_held_rel",  8'(kp.key_held),  8'h0);
        check("kD_valid_rel", 8'(kp.key_valid), 8'h0);
        check("kD_overrun",   8'(kp.overrun),   8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
